// File: rtl/tile_buf_pkg.sv
// rtl/tile_buf_pkg.sv - shared constants, state type and strobe encodings for the tile buffer port
package tile_buf_pkg;

  localparam int LANE_W    = 12;
  localparam int NUM_LANES = 4;
  localparam int WORDS     = 640;

  typedef enum logic {
    SERVE = 1'b0,
    CLEAR = 1'b1
  } state_t;

  // All buffer strobes are active low except gwen, which selects write (1) or read (0).
  localparam logic                 CEN_ON   = 1'b0;
  localparam logic                 CEN_OFF  = 1'b1;
  localparam logic                 GWEN_WR  = 1'b1;
  localparam logic                 GWEN_RD  = 1'b0;
  localparam logic [NUM_LANES-1:0] WEN_ALL  = 4'h0;
  localparam logic [NUM_LANES-1:0] WEN_NONE = 4'hF;

endpackage

// File: rtl/tile_buf_rw_arb.sv
// rtl/tile_buf_rw_arb.sv - read-priority grant with a bounded read streak so pending writes are not starved
module tile_buf_rw_arb #(
  parameter int MAX_RD_STREAK = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic rd_valid,
  input  logic wr_valid,
  output logic rd_grant,
  output logic wr_grant
);

  localparam int SW = $clog2(MAX_RD_STREAK + 1);

  logic [SW-1:0] streak;
  logic          capped;

  assign capped   = (streak == SW'(MAX_RD_STREAK));
  assign rd_grant = en && rd_valid && !(wr_valid && capped);
  assign wr_grant = en && wr_valid && !rd_grant;

  // Only reads that overtake a waiting write count toward the streak.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      streak <= '0;
    end else if (!wr_valid || wr_grant) begin
      streak <= '0;
    end else if (rd_grant) begin
      streak <= streak + 1'b1;
    end
  end

endmodule

// File: rtl/tile_buf_ctrl.sv
// rtl/tile_buf_ctrl.sv - single-port sequencer sharing one tile buffer port between pixel writes, scanout reads and clear
module tile_buf_ctrl #(
  parameter int ADDR_WIDTH    = 10,
  parameter int DATA_WIDTH    = 48,
  parameter int WORDS         = 640,
  parameter int MAX_RD_STREAK = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear_start,
  input  logic [DATA_WIDTH-1:0] clear_value,
  output logic                  clear_busy,
  output logic                  clear_done,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [3:0]            wr_mask,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_valid,
  output logic                  rd_ready,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  rd_data_valid,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  oob_err,
  output logic                  bram_cen,
  output logic [3:0]            bram_wen,
  output logic                  bram_gwen,
  output logic [ADDR_WIDTH-1:0] bram_addr,
  output logic [DATA_WIDTH-1:0] bram_din,
  input  logic [DATA_WIDTH-1:0] bram_dout
);

  import tile_buf_pkg::*;

  localparam logic [ADDR_WIDTH:0]   WORDS_X   = (ADDR_WIDTH + 1)'(WORDS);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(WORDS - 1);

  state_t                  state, state_nx;
  logic [ADDR_WIDTH-1:0]   clr_addr, clr_addr_nx;
  logic [DATA_WIDTH-1:0]   clr_value_q;
  logic                    clear_done_nx;
  logic                    cen_nx, gwen_nx;
  logic [3:0]              wen_nx;
  logic [ADDR_WIDTH-1:0]   addr_nx;
  logic [DATA_WIDTH-1:0]   din_nx;
  logic                    arb_en, rd_grant, wr_grant, rd_oob, wr_oob;
  logic                    rd_p1, rd_oob_p1, rd_oob_p2;

  assign rd_oob = ({1'b0, rd_addr} >= WORDS_X);
  assign wr_oob = ({1'b0, wr_addr} >= WORDS_X);

  // A clear request in the serving cycle takes the port, so nothing else is granted.
  assign arb_en = rst_n && (state == SERVE) && !clear_start;

  tile_buf_rw_arb #(
    .MAX_RD_STREAK(MAX_RD_STREAK)
  ) u_arb (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (arb_en),
    .rd_valid (rd_valid),
    .wr_valid (wr_valid),
    .rd_grant (rd_grant),
    .wr_grant (wr_grant)
  );

  assign rd_ready   = rd_grant;
  assign wr_ready   = wr_grant;
  assign clear_busy = (state == CLEAR);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= SERVE;
      clr_addr    <= '0;
      clr_value_q <= '0;
      clear_done  <= 1'b0;
    end else begin
      state      <= state_nx;
      clr_addr   <= clr_addr_nx;
      clear_done <= clear_done_nx;
      if (state == SERVE && clear_start) begin
        clr_value_q <= clear_value;
      end
    end
  end

  // clr_addr tracks the fill address currently on the port.
  always_comb begin
    state_nx      = state;
    clr_addr_nx   = clr_addr;
    clear_done_nx = 1'b0;
    cen_nx        = CEN_OFF;
    wen_nx        = WEN_NONE;
    gwen_nx       = GWEN_RD;
    addr_nx       = bram_addr;
    din_nx        = bram_din;
    case (state)
      SERVE: begin
        if (clear_start) begin
          state_nx    = CLEAR;
          clr_addr_nx = '0;
          cen_nx      = CEN_ON;
          wen_nx      = WEN_ALL;
          gwen_nx     = GWEN_WR;
          addr_nx     = '0;
          din_nx      = clear_value;
        end else if (rd_grant && !rd_oob) begin
          cen_nx  = CEN_ON;
          addr_nx = rd_addr;
        end else if (wr_grant && !wr_oob && (wr_mask != 4'h0)) begin
          cen_nx  = CEN_ON;
          wen_nx  = ~wr_mask;
          gwen_nx = GWEN_WR;
          addr_nx = wr_addr;
          din_nx  = wr_data;
        end
      end
      CLEAR: begin
        if (clr_addr == LAST_ADDR) begin
          state_nx      = SERVE;
          clear_done_nx = 1'b1;
        end else begin
          clr_addr_nx = clr_addr + 1'b1;
          cen_nx      = CEN_ON;
          wen_nx      = WEN_ALL;
          gwen_nx     = GWEN_WR;
          addr_nx     = clr_addr + 1'b1;
          din_nx      = clr_value_q;
        end
      end
      default: state_nx = SERVE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bram_cen      <= CEN_OFF;
      bram_wen      <= WEN_NONE;
      bram_gwen     <= GWEN_RD;
      bram_addr     <= '0;
      bram_din      <= '0;
      oob_err       <= 1'b0;
      rd_p1         <= 1'b0;
      rd_oob_p1     <= 1'b0;
      rd_data_valid <= 1'b0;
      rd_oob_p2     <= 1'b0;
    end else begin
      bram_cen      <= cen_nx;
      bram_wen      <= wen_nx;
      bram_gwen     <= gwen_nx;
      bram_addr     <= addr_nx;
      bram_din      <= din_nx;
      oob_err       <= oob_err || (rd_grant && rd_oob) || (wr_grant && wr_oob);
      rd_p1         <= rd_grant;
      rd_oob_p1     <= rd_grant && rd_oob;
      rd_data_valid <= rd_p1;
      rd_oob_p2     <= rd_oob_p1;
    end
  end

  // Out-of-range reads still occupy a return slot so responses stay in order.
  assign rd_data = (rd_data_valid && !rd_oob_p2) ? bram_dout : '0;

endmodule

// File: tb/tb_tile_buf_ctrl.sv
// tb/tb_tile_buf_ctrl.sv - directed and randomized checks of tile_buf_ctrl against a word-level buffer model
module tb_tile_buf_ctrl;

  localparam int AW    = 10;
  localparam int DW    = 48;
  localparam int WORDS = 640;
  localparam int MAXS  = 4;

  logic          clk = 1'b0;
  logic          rst_n, clear_start, clear_busy, clear_done;
  logic [DW-1:0] clear_value;
  logic          wr_valid, wr_ready, rd_valid, rd_ready, rd_data_valid, oob_err;
  logic [AW-1:0] wr_addr, rd_addr;
  logic [3:0]    wr_mask;
  logic [DW-1:0] wr_data, rd_data;
  logic          bram_cen, bram_gwen;
  logic [3:0]    bram_wen;
  logic [AW-1:0] bram_addr;
  logic [DW-1:0] bram_din, bram_dout;

  always #5 clk = ~clk;

  tile_buf_ctrl #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WORDS(WORDS), .MAX_RD_STREAK(MAXS)
  ) dut (
    .clk(clk), .rst_n(rst_n), .clear_start(clear_start), .clear_value(clear_value),
    .clear_busy(clear_busy), .clear_done(clear_done),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_mask(wr_mask), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr),
    .rd_data_valid(rd_data_valid), .rd_data(rd_data), .oob_err(oob_err),
    .bram_cen(bram_cen), .bram_wen(bram_wen), .bram_gwen(bram_gwen),
    .bram_addr(bram_addr), .bram_din(bram_din), .bram_dout(bram_dout)
  );

  // Masked single-port buffer with registered read data.
  logic [DW-1:0] ram [0:1023];
  logic          ram_clr = 1'b1;
  always @(posedge clk) begin
    if (ram_clr) begin
      for (int i = 0; i < 1024; i++) ram[i] <= '0;
    end else if (!bram_cen) begin
      if (bram_gwen) begin
        for (int l = 0; l < 4; l++)
          if (!bram_wen[l]) ram[bram_addr][l*12 +: 12] <= bram_din[l*12 +: 12];
      end else begin
        bram_dout <= ram[bram_addr];
      end
    end
  end

  typedef struct {
    int            due;
    logic [DW-1:0] d;
  } rd_exp_t;

  int            n_cmp = 0;
  int            n_bad = 0;
  int            cyc_n = 0;
  logic [DW-1:0] ref_mem [0:1023];
  rd_exp_t       rq[$];
  int            wait_run;
  int            clr_at;
  logic [DW-1:0] clr_val;
  logic          exp_oob;
  logic          p_cen, p_gwen;
  logic [3:0]    p_wen;
  logic [AW-1:0] p_addr;
  logic [DW-1:0] p_din;
  logic [DW-1:0] last_rd;
  logic          last_wr_obs;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    rd_valid = 1'b0; wr_valid = 1'b0; clear_start = 1'b0;
  endtask

  task automatic set_wr(input int a, input logic [3:0] m, input logic [DW-1:0] d);
    wr_valid = 1'b1; wr_addr = AW'(a); wr_mask = m; wr_data = d;
  endtask

  task automatic set_rd(input int a);
    rd_valid = 1'b1; rd_addr = AW'(a);
  endtask

  task automatic model_reset();
    rq.delete();
    wait_run = 0; clr_at = -100000; exp_oob = 1'b0;
    p_cen = 1'b1; p_gwen = 1'b0; p_wen = 4'hF; p_addr = '0; p_din = '0;
  endtask

  // One clock: check everything the spec fixes for this cycle, then advance the model.
  task automatic cyc();
    logic          rg, wg, busy_w, acc, roob, woob;
    logic          e_cen, e_gwen;
    logic [3:0]    e_wen;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_din;
    rd_exp_t       e;
    @(negedge clk);
    busy_w = (cyc_n >= clr_at + 1) && (cyc_n <= clr_at + WORDS);
    acc    = clear_start && !busy_w;
    if (busy_w || acc) begin
      rg = 1'b0; wg = 1'b0;
    end else begin
      rg = rd_valid && !(wr_valid && wait_run == MAXS);
      wg = wr_valid && !rg;
    end
    last_wr_obs = wr_ready;
    check("rd_ready", rd_ready, rg);
    check("wr_ready", wr_ready, wg);
    check("clear_busy", clear_busy, busy_w);
    check("clear_done", clear_done, cyc_n == clr_at + WORDS + 1);
    check("oob_err", oob_err, exp_oob);
    if (rq.size() > 0 && rq[0].due == cyc_n) begin
      check("rd_data_valid", rd_data_valid, 1'b1);
      check("rd_data", rd_data, rq[0].d);
      last_rd = rd_data;
      void'(rq.pop_front());
    end else begin
      check("rd_data_valid", rd_data_valid, 1'b0);
    end
    if (busy_w) begin
      e_cen = 1'b0; e_gwen = 1'b1; e_wen = 4'h0; e_addr = AW'(cyc_n - clr_at - 1); e_din = clr_val;
      ref_mem[cyc_n - clr_at - 1] = clr_val;
    end else begin
      e_cen = p_cen; e_gwen = p_gwen; e_wen = p_wen; e_addr = p_addr; e_din = p_din;
    end
    check("bram_cen", bram_cen, e_cen);
    check("bram_wen", bram_wen, e_wen);
    check("bram_gwen", bram_gwen, e_gwen);
    if (!e_cen) check("bram_addr", bram_addr, e_addr);
    if (!e_cen && e_gwen) check("bram_din", bram_din, e_din);

    if (!wr_valid || wg) wait_run = 0;
    else if (rg) wait_run++;
    p_cen = 1'b1; p_gwen = 1'b0; p_wen = 4'hF;
    roob = (int'(rd_addr) >= WORDS);
    woob = (int'(wr_addr) >= WORDS);
    if (acc) begin
      clr_at = cyc_n; clr_val = clear_value;
    end
    if (rg) begin
      e.due = cyc_n + 2;
      e.d   = roob ? '0 : ref_mem[rd_addr];
      rq.push_back(e);
      if (roob) exp_oob = 1'b1;
      else begin p_cen = 1'b0; p_addr = rd_addr; end
    end
    if (wg) begin
      if (woob) exp_oob = 1'b1;
      else if (wr_mask != 4'h0) begin
        p_cen = 1'b0; p_gwen = 1'b1; p_wen = ~wr_mask; p_addr = wr_addr; p_din = wr_data;
        for (int l = 0; l < 4; l++)
          if (wr_mask[l]) ref_mem[wr_addr][l*12 +: 12] = wr_data[l*12 +: 12];
      end
    end
    @(posedge clk); #1;
    cyc_n++;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) ref_mem[i] = '0;
    rst_n = 1'b0; clear_start = 1'b1; clear_value = '1;
    rd_valid = 1'b1; rd_addr = '0; wr_valid = 1'b1; wr_addr = '0; wr_mask = 4'hF; wr_data = '1;
    last_rd = '0; last_wr_obs = 1'b0;

    // Reset with every request asserted
    repeat (3) begin @(posedge clk); #1; end
    @(negedge clk);
    check("rst_rd_ready", rd_ready, 1'b0);
    check("rst_wr_ready", wr_ready, 1'b0);
    check("rst_cen", bram_cen, 1'b1);
    check("rst_wen", bram_wen, 4'hF);
    check("rst_gwen", bram_gwen, 1'b0);
    check("rst_addr", bram_addr, '0);
    check("rst_din", bram_din, '0);
    check("rst_busy", clear_busy, 1'b0);
    check("rst_done", clear_done, 1'b0);
    check("rst_rdv", rd_data_valid, 1'b0);
    check("rst_oob", oob_err, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1; ram_clr = 1'b0; idle();
    model_reset();

    // Masked write, then an immediately following read of the same word
    set_wr(5, 4'hF, 48'h111222333444); cyc();
    set_wr(5, 4'b0101, 48'hAAABBBCCCDDD); cyc();
    idle(); set_rd(5); cyc();
    idle(); cyc(); cyc();
    check("masked_merge", last_rd, 48'h111BBB333DDD);

    // Continuous contention: four reads then one write, repeating
    cyc();
    for (int i = 0; i < 20; i++) begin
      set_rd($urandom_range(0, WORDS - 1));
      set_wr($urandom_range(0, WORDS - 1), 4'hF, DW'({$urandom(), $urandom()}));
      cyc();
      check("rw_pattern", last_wr_obs, (i % 5) == 4);
    end
    idle(); cyc(); cyc(); cyc();

    // Full clear with a read in flight and requests held throughout
    set_rd(7); cyc();
    idle(); clear_start = 1'b1; clear_value = 48'h123456789ABC; cyc();
    clear_start = 1'b0;
    for (int i = 0; i < WORDS; i++) begin
      set_rd($urandom_range(0, WORDS - 1));
      set_wr(10, 4'hF, DW'({$urandom(), $urandom()}));
      clear_start = (i == 100);
      clear_value = '0;
      cyc();
    end
    idle(); cyc();
    set_rd(0); cyc();
    set_rd(639); cyc();
    set_rd(320); cyc();
    idle(); cyc(); cyc();
    check("clear_readback", last_rd, 48'h123456789ABC);

    // Out-of-range write and read
    set_wr(640, 4'hF, 48'hFFFFFFFFFFFF); cyc();
    idle(); cyc();
    check("oob_set", oob_err, 1'b1);
    set_rd(700); cyc();
    idle(); cyc(); cyc();
    check("oob_rd_zero", last_rd, '0);
    check("oob_sticky", oob_err, 1'b1);

    // Reset in the middle of a sweep
    clear_start = 1'b1; clear_value = 48'h0F0F0F0F0F0F; cyc();
    idle();
    repeat (300) cyc();
    rst_n = 1'b0;
    @(negedge clk);
    check("sweep_addr", bram_addr, 10'd300);
    check("sweep_busy", clear_busy, 1'b1);
    ref_mem[300] = 48'h0F0F0F0F0F0F;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("abort_busy", clear_busy, 1'b0);
    check("abort_cen", bram_cen, 1'b1);
    check("abort_done", clear_done, 1'b0);
    @(posedge clk); #1;
    cyc_n++;
    model_reset();
    repeat (700) cyc();
    set_rd(299); cyc();
    set_rd(300); cyc();
    set_rd(301); cyc();
    idle(); cyc(); cyc();

    // Randomized traffic over a small window plus occasional out-of-range addresses
    for (int i = 0; i < 400; i++) begin
      rd_valid = 1'($urandom_range(0, 1));
      rd_addr  = ($urandom_range(0, 7) == 0) ? AW'(WORDS + $urandom_range(0, 383)) : AW'($urandom_range(0, 15));
      wr_valid = 1'($urandom_range(0, 1));
      wr_addr  = ($urandom_range(0, 7) == 0) ? AW'(WORDS + $urandom_range(0, 383)) : AW'($urandom_range(0, 15));
      wr_mask  = 4'($urandom_range(0, 15));
      wr_data  = DW'({$urandom(), $urandom()});
      cyc();
    end
    idle(); cyc(); cyc(); cyc();
    check("rd_drain", rq.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
